interrupt_controller: RTL and testbench

Holds the CPU interrupt state (IF, IE, IME) and feeds the control unit's interrupt inputs. It latches peripheral requests, exposes the IF/IE registers to the memory bus, and applies the delayed-EI rule. It arbitrates pending interrupts by fixed priority and runs the dispatch handshake, supplying the RST vector while the control unit pushes PC and jumps.

---
 rtl/interrupt_controller.sv | 153 +++++++++++++++
 tb/tb_interrupt_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// Interrupt controller: IF/IE/IME state, delayed-EI handling, fixed-priority
// arbitration and the two-state dispatch handshake with the control unit.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_IDLE      | no dispatch in progress; o_Dispatch_Req may be raised
// ST_DISPATCH  | acknowledge taken; o_Vector holds the RST address of r_idx
module interrupt_controller (
    input  logic       i_Clk,
    input  logic       i_nRst,
    input  logic       i_Enable,
    input  logic [4:0] i_Request,
    input  logic [7:0] i_Data,
    input  logic       i_Write_IF,
    input  logic       i_Write_IE,
    output logic [7:0] o_IF_Data,
    output logic [7:0] o_IE_Data,
    input  logic       i_EI,
    input  logic       i_DI,
    input  logic       i_RETI,
    input  logic       i_Instr_Boundary,
    output logic [4:0] o_Pending,
    output logic       o_Dispatch_Req,
    input  logic       i_Handle_Interrupt,
    output logic [7:0] o_Vector,
    input  logic       i_Dispatch_Done
);

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_DISPATCH = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [4:0] r_if;
    logic [7:0] r_ie;
    logic       r_ime;
    logic       r_ime_delay;
    logic       r_bnd_seen;     // one boundary already counted since EI
    logic [2:0] r_idx;

    logic [4:0] w_pending;
    logic       w_dispatch_req;
    logic       w_ack;
    logic [2:0] w_prio_idx;
    logic [4:0] w_if_next;
    logic [7:0] w_ie_next;
    logic       w_ime_next;
    logic       w_ime_delay_next;
    logic       w_bnd_seen_next;

    assign w_pending      = r_ie[4:0] & r_if;
    assign w_dispatch_req = r_ime & (|w_pending) & (r_state == ST_IDLE);
    assign w_ack          = i_Handle_Interrupt & w_dispatch_req;

    assign o_Pending      = w_pending;
    assign o_Dispatch_Req = w_dispatch_req;
    assign o_IF_Data      = {3'b111, r_if};
    assign o_IE_Data      = r_ie;
    assign o_Vector       = (r_state == ST_DISPATCH) ? {2'b01, r_idx, 3'b000} : 8'h00;

    // Fixed priority: lowest set pending bit wins (scan from high to low so
    // the last assignment is the lowest index).
    always_comb begin
        w_prio_idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (w_pending[i]) begin
                w_prio_idx = 3'(i);
            end
        end
    end

    // IF/IE next value: write, then acknowledge clear, then new requests win.
    always_comb begin
        w_if_next = i_Write_IF ? i_Data[4:0] : r_if;
        if (w_ack) begin
            w_if_next = w_if_next & ~(5'b00001 << w_prio_idx);
        end
        w_if_next = w_if_next | i_Request;
        w_ie_next = i_Write_IE ? i_Data : r_ie;
    end

    // IME next value: DI dominates, then acknowledge, RETI, EI, boundary count.
    always_comb begin
        w_ime_next       = r_ime;
        w_ime_delay_next = r_ime_delay;
        w_bnd_seen_next  = r_bnd_seen;
        if (i_DI || w_ack) begin
            w_ime_next       = 1'b0;
            w_ime_delay_next = 1'b0;
            w_bnd_seen_next  = 1'b0;
        end else if (i_RETI) begin
            w_ime_next       = 1'b1;
            w_ime_delay_next = 1'b0;
            w_bnd_seen_next  = 1'b0;
        end else if (i_EI) begin
            if (!r_ime) begin
                w_ime_delay_next = 1'b1;
                w_bnd_seen_next  = 1'b0;
            end
        end else if (r_ime_delay && i_Instr_Boundary) begin
            if (r_bnd_seen) begin
                w_ime_next       = 1'b1;
                w_ime_delay_next = 1'b0;
                w_bnd_seen_next  = 1'b0;
            end else begin
                w_bnd_seen_next  = 1'b1;
            end
        end
    end

    // Dispatch FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     if (w_ack)           w_state_next = ST_DISPATCH;
            ST_DISPATCH: if (i_Dispatch_Done) w_state_next = ST_IDLE;
            default:                          w_state_next = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            r_state <= ST_IDLE;
        end else if (i_Enable) begin
            r_state <= w_state_next;
        end
    end

    // Interrupt registers and the latched dispatch index.
    always_ff @(posedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            r_if        <= 5'd0;
            r_ie        <= 8'd0;
            r_ime       <= 1'b0;
            r_ime_delay <= 1'b0;
            r_bnd_seen  <= 1'b0;
            r_idx       <= 3'd0;
        end else if (i_Enable) begin
            r_if        <= w_if_next;
            r_ie        <= w_ie_next;
            r_ime       <= w_ime_next;
            r_ime_delay <= w_ime_delay_next;
            r_bnd_seen  <= w_bnd_seen_next;
            if (w_ack) begin
                r_idx <= w_prio_idx;
            end
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: a behavioural model predicts the
// outputs after every clock edge; a monitor compares them one cycle later.
module tb_interrupt_controller;

    typedef struct {
        bit       nrst, en;
        bit [4:0] req;
        bit [7:0] data;
        bit       wif, wie, ei, di, reti, bnd, hi, done;
    } stim_t;

    typedef struct {
        bit [4:0] pend;
        bit       dreq;
        bit [7:0] vec, ifd, ied;
    } exp_t;

    logic       clk = 1'b0;
    logic       nrst, en;
    logic [4:0] req;
    logic [7:0] data;
    logic       wif, wie, ei, di, reti, bnd, hi, done;
    logic [7:0] o_if, o_ie, o_vec;
    logic [4:0] o_pend;
    logic       o_dreq;

    int checks   = 0;
    int failures = 0;
    exp_t sb_q[$];

    // model state, kept as plain integers
    int m_if, m_ie, m_ime, m_need, m_disp, m_idx;

    always #5 clk = ~clk;

    interrupt_controller dut (
        .i_Clk(clk), .i_nRst(nrst), .i_Enable(en), .i_Request(req), .i_Data(data),
        .i_Write_IF(wif), .i_Write_IE(wie), .o_IF_Data(o_if), .o_IE_Data(o_ie),
        .i_EI(ei), .i_DI(di), .i_RETI(reti), .i_Instr_Boundary(bnd),
        .o_Pending(o_pend), .o_Dispatch_Req(o_dreq), .i_Handle_Interrupt(hi),
        .o_Vector(o_vec), .i_Dispatch_Done(done)
    );

    function automatic stim_t idle();
        stim_t s;
        s = '{nrst: 1'b1, en: 1'b1, req: 5'd0, data: 8'd0, wif: 1'b0, wie: 1'b0,
              ei: 1'b0, di: 1'b0, reti: 1'b0, bnd: 1'b0, hi: 1'b0, done: 1'b0};
        return s;
    endfunction

    function automatic int lowest_set(int v);
        for (int i = 0; i < 5; i++) if ((v >> i) & 1) return i;
        return 0;
    endfunction

    function automatic exp_t model_outputs();
        exp_t e;
        int   p;
        p      = m_ie & m_if & 31;
        e.pend = 5'(p);
        e.dreq = (m_ime == 1) && (p != 0) && (m_disp == 0);
        e.vec  = m_disp ? 8'(64 + 8 * m_idx) : 8'd0;
        e.ifd  = 8'(224 + m_if);
        e.ied  = 8'(m_ie);
        return e;
    endfunction

    task automatic model_step(input stim_t s);
        int  p, nif;
        bit  ack;
        if (!s.nrst) begin
            m_if = 0; m_ie = 0; m_ime = 0; m_need = 0; m_disp = 0; m_idx = 0;
        end else if (s.en) begin
            p   = m_ie & m_if & 31;
            ack = s.hi && m_ime == 1 && p != 0 && m_disp == 0;
            nif = s.wif ? (s.data & 31) : m_if;
            if (ack) begin
                m_idx = lowest_set(p);
                nif   = nif & ~(1 << m_idx);
            end
            m_if = nif | s.req;
            if (s.wie) m_ie = s.data;
            if (s.di || ack) begin
                m_ime = 0; m_need = 0;
            end else if (s.reti) begin
                m_ime = 1; m_need = 0;
            end else if (s.ei) begin
                if (m_ime == 0) m_need = 2;
            end else if (m_need > 0 && s.bnd) begin
                m_need--;
                if (m_need == 0) m_ime = 1;
            end
            if (m_disp && s.done) m_disp = 0;
            else if (ack)         m_disp = 1;
        end
    endtask

    // Apply one cycle of stimulus at the falling edge and predict the result.
    task automatic drive(input stim_t s);
        @(negedge clk);
        nrst = s.nrst; en = s.en; req = s.req; data = s.data;
        wif = s.wif; wie = s.wie; ei = s.ei; di = s.di; reti = s.reti;
        bnd = s.bnd; hi = s.hi; done = s.done;
        model_step(s);
        sb_q.push_back(model_outputs());
    endtask

    task automatic after_edge();
        @(posedge clk);
        #3;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Monitor: pop one prediction per clock and compare against the DUT.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_pending", o_pend, e.pend);
                chk("sb_dreq",    o_dreq, e.dreq);
                chk("sb_vector",  o_vec,  e.vec);
                chk("sb_if",      o_if,   e.ifd);
                chk("sb_ie",      o_ie,   e.ied);
            end
        end
    end

    initial begin
        stim_t s;
        nrst = 1'b0; en = 1'b1; req = '0; data = '0; wif = 0; wie = 0;
        ei = 0; di = 0; reti = 0; bnd = 0; hi = 0; done = 0;
        m_if = 0; m_ie = 0; m_ime = 0; m_need = 0; m_disp = 0; m_idx = 0;

        s = idle(); s.nrst = 0; drive(s); drive(s);
        s = idle(); drive(s);

        // priority: Timer beats Joypad
        s = idle(); s.wie = 1; s.data = 8'h1F; drive(s);
        s = idle(); s.reti = 1; drive(s);
        s = idle(); s.req = 5'b10100; drive(s);
        s = idle(); s.hi = 1; drive(s);
        after_edge();
        chk("prio_vec_timer", o_vec, 8'h50);
        chk("prio_if_after_ack", o_if, 8'hF0);
        s = idle(); s.done = 1; drive(s);
        after_edge();
        chk("vec_after_done", o_vec, 8'h00);
        s = idle(); s.reti = 1; drive(s);
        s = idle(); s.hi = 1; drive(s);
        after_edge();
        chk("prio_vec_joypad", o_vec, 8'h60);
        chk("prio_if_empty", o_if, 8'hE0);

        // reset while dispatching
        s = idle(); s.nrst = 0; drive(s);
        after_edge();
        chk("rst_if", o_if, 8'hE0);
        chk("rst_ie", o_ie, 8'h00);
        chk("rst_vec", o_vec, 8'h00);
        chk("rst_dreq", o_dreq, 0);

        // HALT wake without IME
        s = idle(); s.wie = 1; s.data = 8'h04; drive(s);
        s = idle(); s.req = 5'b00100; drive(s);
        after_edge();
        chk("halt_pending", o_pend, 5'b00100);
        chk("halt_dreq", o_dreq, 0);

        // EI delay: second boundary enables
        s = idle(); s.ei = 1; drive(s);
        s = idle(); drive(s);
        s = idle(); s.bnd = 1; drive(s);
        s = idle(); drive(s);
        after_edge();
        chk("ei_after_bnd1", o_dreq, 0);
        s = idle(); s.bnd = 1; drive(s);
        after_edge();
        chk("ei_after_bnd2", o_dreq, 1);

        // EI cancelled by DI before the second boundary
        s = idle(); s.di = 1; drive(s);
        s = idle(); s.ei = 1; drive(s);
        s = idle(); s.bnd = 1; drive(s);
        s = idle(); s.di = 1; drive(s);
        s = idle(); s.bnd = 1; drive(s);
        s = idle(); drive(s);
        after_edge();
        chk("ei_di_cancel", o_dreq, 0);

        // ack of VBlank alongside a new VBlank request
        s = idle(); s.wie = 1; s.data = 8'h1F; drive(s);
        s = idle(); s.req = 5'b00001; drive(s);
        s = idle(); s.reti = 1; drive(s);
        s = idle(); s.hi = 1; s.req = 5'b00001; drive(s);
        after_edge();
        chk("ack_req_same_vec", o_vec, 8'h40);
        chk("ack_req_same_if", o_if, 8'hE5);
        s = idle(); s.done = 1; drive(s);

        // IF write of zero alongside Serial request
        s = idle(); s.wif = 1; s.data = 8'h00; s.req = 5'b01000; drive(s);
        after_edge();
        chk("wif_req_same", o_if, 8'hE8);

        // enable gating
        s = idle(); s.en = 0; s.req = 5'h1F; s.wie = 1; s.data = 8'h00; drive(s);
        after_edge();
        chk("gate_if", o_if, 8'hE8);
        chk("gate_ie", o_ie, 8'h1F);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            s.nrst = ($urandom_range(99) != 0);
            s.en   = ($urandom_range(9) != 0);
            for (int b = 0; b < 5; b++) s.req[b] = ($urandom_range(11) == 0);
            s.data = 8'($urandom);
            s.wif  = ($urandom_range(15) == 0);
            s.wie  = ($urandom_range(15) == 0);
            s.ei   = ($urandom_range(9) == 0);
            s.di   = ($urandom_range(24) == 0);
            s.reti = ($urandom_range(9) == 0);
            s.bnd  = ($urandom_range(3) == 0);
            s.hi   = ($urandom_range(2) == 0);
            s.done = ($urandom_range(3) == 0);
            drive(s);
        end
        s = idle(); drive(s);

        for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(posedge clk);
        #3;
        checks++;
        if (sb_q.size() > 0) begin
            failures++;
            $display("FAIL sb_drain got=%0d exp=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
